// File: rtl/countdown_timer.sv
// Countdown timer with start/stop/pause and optional auto-reload.
// Emits a one-cycle done pulse at every terminal count.
module countdown_timer #(
  parameter int W = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [W-1:0] load_val,
  input  logic         start,
  input  logic         stop,
  input  logic         pause,
  input  logic         auto_reload,
  output logic [W-1:0] count,
  output logic         busy,
  output logic         paused,
  output logic         done
);

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    PAUSED
  } state_t;

  localparam logic [W-1:0] ONE  = W'(1);
  localparam logic [W-1:0] ZERO = '0;

  state_t         state_q, state_d;
  logic [W-1:0]   count_q, count_d;
  logic [W-1:0]   reload_q, reload_d;
  logic           done_q, done_d;

  // Next-state: stop beats start beats pause beats decrement.
  always_comb begin
    state_d  = state_q;
    count_d  = count_q;
    reload_d = reload_q;
    done_d   = 1'b0;
    if (stop) begin
      state_d = IDLE;
      count_d = ZERO;
    end else if (start) begin
      reload_d = load_val;
      count_d  = load_val;
      if (load_val == ZERO) begin
        state_d = IDLE;
        done_d  = 1'b1;
      end else begin
        state_d = RUN;
      end
    end else begin
      unique case (state_q)
        RUN: begin
          if (pause) begin
            state_d = PAUSED;
          end else if (count_q == ONE) begin
            done_d = 1'b1;
            if (auto_reload) begin
              count_d = reload_q;
            end else begin
              count_d = ZERO;
              state_d = IDLE;
            end
          end else if (count_q > ONE) begin
            count_d = count_q - ONE;
          end
        end
        PAUSED: begin
          if (!pause) state_d = RUN;
        end
        default: ;
      endcase
    end
  end

  // State and registered outputs; reset clears all progress at once.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= IDLE;
      count_q  <= ZERO;
      reload_q <= ZERO;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      count_q  <= count_d;
      reload_q <= reload_d;
      done_q   <= done_d;
    end
  end

  assign count  = count_q;
  assign done   = done_q;
  assign busy   = (state_q != IDLE);
  assign paused = (state_q == PAUSED);

endmodule

// File: tb/tb_countdown_timer.sv
// Bench for countdown_timer: behavioural model compared every cycle,
// directed scenarios with literal expectations, then random traffic.
module tb_countdown_timer;

  localparam int W = 4;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic [W-1:0] load_val = '0;
  logic         start = 1'b0;
  logic         stop = 1'b0;
  logic         pause = 1'b0;
  logic         auto_reload = 1'b0;
  logic [W-1:0] count;
  logic         busy;
  logic         paused;
  logic         done;

  int n_chk = 0;
  int n_pass = 0;

  countdown_timer #(.W(W)) dut (
    .clk(clk),
    .rst(rst),
    .load_val(load_val),
    .start(start),
    .stop(stop),
    .pause(pause),
    .auto_reload(auto_reload),
    .count(count),
    .busy(busy),
    .paused(paused),
    .done(done)
  );

  always #5 clk = ~clk;

  // Model: mode 0 = stopped, 1 = counting, 2 = frozen.
  typedef struct {
    int mode;
    int cnt;
    int rl;
    bit dn;
  } m_t;

  localparam m_t M0 = '{mode: 0, cnt: 0, rl: 0, dn: 0};
  m_t m = M0;

  function automatic m_t nxt(m_t c, bit s, bit p, bit pa, bit ar, int lv);
    m_t n = c;
    n.dn = 0;
    if (p) begin
      n.mode = 0;
      n.cnt = 0;
    end else if (s) begin
      n.rl = lv;
      n.cnt = lv;
      n.mode = (lv == 0) ? 0 : 1;
      n.dn = (lv == 0);
    end else if (c.mode == 1 && pa) begin
      n.mode = 2;
    end else if (c.mode == 1 && c.cnt == 1) begin
      n.dn = 1;
      n.cnt = ar ? c.rl : 0;
      n.mode = ar ? 1 : 0;
    end else if (c.mode == 1 && c.cnt > 1) begin
      n.cnt = c.cnt - 1;
    end else if (c.mode == 2 && !pa) begin
      n.mode = 1;
    end
    return n;
  endfunction

  always @(posedge clk or posedge rst) begin
    if (rst) m <= M0;
    else m <= nxt(m, start, stop, pause, auto_reload, int'(load_val));
  end

  task automatic chk(string nm, int got, int exp);
    n_chk++;
    if (got == exp) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d at %0t", nm, got, exp, $time);
  endtask

  // Every-cycle comparison against the model.
  always @(negedge clk) begin
    chk("m_count", int'(count), m.cnt);
    chk("m_busy", int'(busy), int'(m.mode != 0));
    chk("m_paused", int'(paused), int'(m.mode == 2));
    chk("m_done", int'(done), int'(m.dn));
  end

  // Apply inputs (at posedge+1), then advance one edge and settle.
  task automatic step(bit s, bit p, bit pa, bit ar, int lv);
    start = s;
    stop = p;
    pause = pa;
    auto_reload = ar;
    load_val = W'(lv);
    @(posedge clk);
    #1;
  endtask

  task automatic idle(int n, bit ar);
    for (int i = 0; i < n; i++) step(0, 0, 0, ar, 0);
  endtask

  initial begin
    #1;
    chk("rst_count", int'(count), 0);
    chk("rst_busy", int'(busy), 0);
    chk("rst_done", int'(done), 0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    idle(1, 0);

    // One-shot 5
    step(1, 0, 0, 0, 5);
    chk("os_first", int'(count), 5);
    chk("os_busy", int'(busy), 1);
    idle(3, 0);
    chk("os_two", int'(count), 2);
    idle(1, 0);
    chk("os_one", int'(count), 1);
    chk("os_nodone", int'(done), 0);
    idle(1, 0);
    chk("os_zero", int'(count), 0);
    chk("os_done", int'(done), 1);
    chk("os_idle", int'(busy), 0);
    idle(1, 0);
    chk("os_done_off", int'(done), 0);

    // Auto-reload 3
    step(1, 0, 0, 1, 3);
    idle(2, 1);
    chk("ar_one", int'(count), 1);
    idle(1, 1);
    chk("ar_reload", int'(count), 3);
    chk("ar_done", int'(done), 1);
    chk("ar_busy", int'(busy), 1);
    idle(3, 1);
    chk("ar_done2", int'(done), 1);
    idle(2, 0);
    chk("ar_last", int'(count), 1);
    idle(1, 0);
    chk("ar_stop_cnt", int'(count), 0);
    chk("ar_stop_done", int'(done), 1);
    chk("ar_stop_busy", int'(busy), 0);

    // Pause at 6
    step(1, 0, 0, 0, 8);
    idle(2, 0);
    chk("pz_at6", int'(count), 6);
    for (int i = 0; i < 4; i++) begin
      step(0, 0, 1, 0, 0);
      chk("pz_hold", int'(count), 6);
      chk("pz_flag", int'(paused), 1);
    end
    idle(1, 0);
    chk("pz_resume_hold", int'(count), 6);
    chk("pz_resume_flag", int'(paused), 0);
    idle(1, 0);
    chk("pz_dec", int'(count), 5);
    step(0, 1, 0, 0, 0);

    // Priority
    step(1, 0, 0, 0, 5);
    idle(1, 0);
    step(1, 1, 0, 0, 9);
    chk("pr_stop_cnt", int'(count), 0);
    chk("pr_stop_busy", int'(busy), 0);
    chk("pr_stop_done", int'(done), 0);
    step(1, 0, 0, 0, 5);
    idle(1, 0);
    step(1, 0, 0, 0, 9);
    chk("pr_restart", int'(count), 9);
    chk("pr_nodone", int'(done), 0);
    step(0, 1, 0, 0, 0);

    // Zero load
    step(1, 0, 0, 1, 0);
    chk("z_done", int'(done), 1);
    chk("z_busy", int'(busy), 0);
    idle(1, 1);
    chk("z_done_off", int'(done), 0);
    chk("z_busy2", int'(busy), 0);

    // Max load with reload, never zero
    step(1, 0, 0, 1, 15);
    for (int i = 0; i < 40; i++) begin
      idle(1, 1);
      chk("max_nonzero", int'(count != 0), 1);
    end
    step(0, 1, 0, 0, 0);

    // Async reset mid-count
    step(1, 0, 0, 0, 9);
    idle(2, 0);
    chk("ar7", int'(count), 7);
    #2;
    rst = 1'b1;
    #1;
    chk("async_cnt", int'(count), 0);
    chk("async_busy", int'(busy), 0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    step(1, 0, 0, 0, 2);
    idle(1, 0);
    chk("post_rst_one", int'(count), 1);
    idle(1, 0);
    chk("post_rst_done", int'(done), 1);

    // Random traffic
    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(0, 99) == 0) rst = 1'b1;
      else rst = 1'b0;
      step($urandom_range(0, 9) == 0, $urandom_range(0, 24) == 0,
           $urandom_range(0, 4) == 0, $urandom_range(0, 1) == 1,
           int'($urandom_range(0, 15)));
    end
    rst = 1'b0;
    idle(2, 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
